// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, PC sources,
// instruction opcodes and ALU operations.
package control_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  localparam logic [1:0] PC_SRC_INC    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // Codes 13..15 are undefined.
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_ORI  = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;
  localparam logic [3:0] OP_BNE  = 4'd10;
  localparam logic [3:0] OP_JUMP = 4'd11;
  localparam logic [3:0] OP_HALT = 4'd12;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode classifier: instruction class flags plus the ALU
// operation and operand-B select used while the instruction executes.
module control_decode
  import control_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 4
) (
  input  logic [OPCODE_W-1:0] op,
  output logic                is_r,
  output logic                is_i,
  output logic                is_lw,
  output logic                is_sw,
  output logic                is_beq,
  output logic                is_bne,
  output logic                is_jump,
  output logic                is_halt,
  output logic                illegal,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src
);

  always_comb begin
    is_r    = 1'b0;
    is_i    = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_jump = 1'b0;
    is_halt = 1'b0;
    illegal = 1'b0;
    alu_op  = ALU_OP_W'(ALU_ADD);
    alu_src = 1'b0;
    case (op)
      OPCODE_W'(OP_ADD):  is_r = 1'b1;
      OPCODE_W'(OP_SUB):  begin is_r = 1'b1; alu_op = ALU_OP_W'(ALU_SUB); end
      OPCODE_W'(OP_AND):  begin is_r = 1'b1; alu_op = ALU_OP_W'(ALU_AND); end
      OPCODE_W'(OP_OR):   begin is_r = 1'b1; alu_op = ALU_OP_W'(ALU_OR);  end
      OPCODE_W'(OP_XOR):  begin is_r = 1'b1; alu_op = ALU_OP_W'(ALU_XOR); end
      OPCODE_W'(OP_ADDI): begin is_i = 1'b1; alu_src = 1'b1; end
      OPCODE_W'(OP_ORI):  begin is_i = 1'b1; alu_src = 1'b1; alu_op = ALU_OP_W'(ALU_OR); end
      OPCODE_W'(OP_LW):   begin is_lw = 1'b1; alu_src = 1'b1; end
      OPCODE_W'(OP_SW):   begin is_sw = 1'b1; alu_src = 1'b1; end
      OPCODE_W'(OP_BEQ):  begin is_beq = 1'b1; alu_op = ALU_OP_W'(ALU_SUB); end
      OPCODE_W'(OP_BNE):  begin is_bne = 1'b1; alu_op = ALU_OP_W'(ALU_SUB); end
      OPCODE_W'(OP_JUMP): is_jump = 1'b1;
      OPCODE_W'(OP_HALT): is_halt = 1'b1;
      default:            illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback over one
// unified memory with mem_ready handshake, timeout/illegal faults and halt.
module control_fsm
  import control_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 4,
  parameter int STRICT      = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                stall,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halt,
  output logic                fault,
  output logic [2:0]          state_o,
  output logic                retired,
  output logic [CNT_W-1:0]    retired_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d, dec_op;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic is_r, is_i, is_lw, is_sw, is_beq, is_bne, is_jump, is_halt, illegal;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_alu_src;

  logic ir_write_c, pc_write_c, iord_c, mem_read_c, mem_write_c;
  logic mem_to_reg_c, reg_write_c, alu_src_c, halt_c, fault_c, retired_c;
  logic [1:0]          pc_src_c;
  logic [ALU_OP_W-1:0] alu_op_c;

  // DECODE must act on the incoming opcode before it lands in op_q.
  assign dec_op = (state_q == S_DECODE) ? opcode : op_q;

  control_decode #(
    .OPCODE_W(OPCODE_W),
    .ALU_OP_W(ALU_OP_W)
  ) u_decode (
    .op      (dec_op),
    .is_r    (is_r),
    .is_i    (is_i),
    .is_lw   (is_lw),
    .is_sw   (is_sw),
    .is_beq  (is_beq),
    .is_bne  (is_bne),
    .is_jump (is_jump),
    .is_halt (is_halt),
    .illegal (illegal),
    .alu_op  (dec_alu_op),
    .alu_src (dec_alu_src)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wait_d       = wait_q;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = PC_SRC_INC;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_c    = 1'b0;
    alu_op_c     = ALU_OP_W'(ALU_ADD);
    halt_c       = 1'b0;
    fault_c      = 1'b0;
    retired_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_jump) begin
          pc_write_c = 1'b1;
          pc_src_c   = PC_SRC_JUMP;
          retired_c  = 1'b1;
          state_d    = S_FETCH;
        end else if (illegal) begin
          if (STRICT != 0) begin
            state_d = S_FAULT;
          end else begin
            retired_c = 1'b1;
            state_d   = S_FETCH;
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op_c  = dec_alu_op;
        alu_src_c = dec_alu_src;
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_beq || is_bne) begin
          pc_write_c = is_beq ? zero : !zero;
          pc_src_c   = PC_SRC_BRANCH;
          retired_c  = 1'b1;
          state_d    = S_FETCH;
        end else if (is_r || is_i) begin
          state_d = S_WB;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_MEM: begin
        // ALU controls stay applied so the unregistered address remains valid.
        alu_op_c    = dec_alu_op;
        alu_src_c   = dec_alu_src;
        iord_c      = 1'b1;
        mem_read_c  = is_lw;
        mem_write_c = is_sw;
        if (mem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            retired_c = 1'b1;
            state_d   = S_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        alu_op_c     = dec_alu_op;
        alu_src_c    = dec_alu_src;
        reg_write_c  = 1'b1;
        mem_to_reg_c = is_lw;
        retired_c    = 1'b1;
        state_d      = S_FETCH;
      end
      S_HALT: begin
        halt_c = 1'b1;
        if (resume) begin
          state_d = S_FETCH;
        end
      end
      S_FAULT: fault_c = 1'b1;
      default: state_d = S_FAULT;
    endcase

    if ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM)) begin
      wait_d = '0;
    end

    // A stall freezes the sequence; a request seen during it is re-issued later.
    if (stall && state_q != S_HALT && state_q != S_FAULT) begin
      state_d     = state_q;
      op_d        = op_q;
      wait_d      = wait_q;
      ir_write_c  = 1'b0;
      pc_write_c  = 1'b0;
      reg_write_c = 1'b0;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      retired_c   = 1'b0;
    end

    cnt_d = cnt_q + CNT_W'(retired_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ir_write    = rst_n & ir_write_c;
  assign pc_write    = rst_n & pc_write_c;
  assign pc_src      = rst_n ? pc_src_c : 2'd0;
  assign iord        = rst_n & iord_c;
  assign mem_read    = rst_n & mem_read_c;
  assign mem_write   = rst_n & mem_write_c;
  assign mem_to_reg  = rst_n & mem_to_reg_c;
  assign reg_write   = rst_n & reg_write_c;
  assign alu_src     = rst_n & alu_src_c;
  assign alu_op      = rst_n ? alu_op_c : '0;
  assign halt        = rst_n & halt_c;
  assign fault       = rst_n & fault_c;
  assign state_o     = rst_n ? state_q : 3'd0;
  assign retired     = rst_n & retired_c;
  assign retired_cnt = rst_n ? cnt_q : '0;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: opcode table, hand-written corner sequences and a
// randomized instruction stream checked against per-instruction latency rules.
module tb_control_fsm;
  import control_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, stall, zero, mem_ready, resume;
  logic [3:0] opcode;

  logic        a_ir_write, a_pc_write, a_iord, a_mem_read, a_mem_write, a_mem_to_reg;
  logic        a_reg_write, a_alu_src, a_halt, a_fault, a_retired;
  logic [1:0]  a_pc_src;
  logic [3:0]  a_alu_op;
  logic [2:0]  a_state_o;
  logic [15:0] a_cnt;

  logic        b_ir_write, b_pc_write, b_iord, b_mem_read, b_mem_write, b_mem_to_reg;
  logic        b_reg_write, b_alu_src, b_halt, b_fault, b_retired;
  logic [1:0]  b_pc_src;
  logic [3:0]  b_alu_op;
  logic [2:0]  b_state_o;
  logic [3:0]  b_cnt;

  logic [35:0] a_all;
  logic [23:0] b_all;
  assign a_all = {a_ir_write, a_pc_write, a_pc_src, a_iord, a_mem_read, a_mem_write,
                  a_mem_to_reg, a_reg_write, a_alu_src, a_alu_op, a_halt, a_fault,
                  a_state_o, a_retired, a_cnt};
  assign b_all = {b_ir_write, b_pc_write, b_pc_src, b_iord, b_mem_read, b_mem_write,
                  b_mem_to_reg, b_reg_write, b_alu_src, b_alu_op, b_halt, b_fault,
                  b_state_o, b_retired, b_cnt};

  control_fsm #(.OPCODE_W(4), .ALU_OP_W(4), .STRICT(0), .MEM_TIMEOUT(15), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .stall(stall), .zero(zero),
    .mem_ready(mem_ready), .resume(resume), .ir_write(a_ir_write), .pc_write(a_pc_write),
    .pc_src(a_pc_src), .iord(a_iord), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write), .alu_src(a_alu_src),
    .alu_op(a_alu_op), .halt(a_halt), .fault(a_fault), .state_o(a_state_o),
    .retired(a_retired), .retired_cnt(a_cnt)
  );

  control_fsm #(.OPCODE_W(4), .ALU_OP_W(4), .STRICT(1), .MEM_TIMEOUT(15), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .stall(stall), .zero(zero),
    .mem_ready(mem_ready), .resume(resume), .ir_write(b_ir_write), .pc_write(b_pc_write),
    .pc_src(b_pc_src), .iord(b_iord), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write), .alu_src(b_alu_src),
    .alu_op(b_alu_op), .halt(b_halt), .fault(b_fault), .state_o(b_state_o),
    .retired(b_retired), .retired_cnt(b_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; resume = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Instruction latency with memory ready at once, straight from the class rules.
  function automatic int lat_of(input logic [3:0] op);
    if (op == OP_LW) return 5;
    if (op == OP_SW) return 4;
    if (op == OP_BEQ || op == OP_BNE) return 3;
    if (op == OP_JUMP) return 2;
    if (op <= OP_ORI) return 4;
    return 2;
  endfunction

  function automatic logic taken_of(input logic [3:0] op, input logic z);
    if (op == OP_JUMP) return 1'b1;
    if (op == OP_BEQ) return z;
    if (op == OP_BNE) return !z;
    return 1'b0;
  endfunction

  typedef struct {
    logic [3:0] op;
    logic       z;
    int         lat;
    logic [3:0] alu;
    logic       src;
    logic [5:0] last; // {pc_write, pc_src, reg_write, mem_to_reg, mem_write} on the retiring cycle
  } vec_t;

  vec_t vecs[15];
  logic mr_seq[8]  = '{1, 0, 0, 0, 0, 0, 1, 0};
  int   lw_st[8]   = '{0, 1, 2, 3, 3, 3, 3, 4};
  logic st_seq[6]  = '{0, 0, 0, 1, 1, 0};
  logic rw_exp[6]  = '{0, 0, 0, 0, 0, 1};
  int   stw_st[6]  = '{0, 1, 2, 4, 4, 4};

  int pulses, iord_cycles, rw_cycles, cyc, stalls, req, waited, exp_cyc, model_cnt;
  logic taken, done;
  logic [3:0] op;
  logic [5:0] last_obs;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{OP_ADD,  1'b0, 4, ALU_ADD, 1'b0, 6'b000100};
    vecs[1]  = '{OP_SUB,  1'b0, 4, ALU_SUB, 1'b0, 6'b000100};
    vecs[2]  = '{OP_AND,  1'b0, 4, ALU_AND, 1'b0, 6'b000100};
    vecs[3]  = '{OP_OR,   1'b0, 4, ALU_OR,  1'b0, 6'b000100};
    vecs[4]  = '{OP_XOR,  1'b0, 4, ALU_XOR, 1'b0, 6'b000100};
    vecs[5]  = '{OP_ADDI, 1'b0, 4, ALU_ADD, 1'b1, 6'b000100};
    vecs[6]  = '{OP_ORI,  1'b0, 4, ALU_OR,  1'b1, 6'b000100};
    vecs[7]  = '{OP_LW,   1'b0, 5, ALU_ADD, 1'b1, 6'b000110};
    vecs[8]  = '{OP_SW,   1'b0, 4, ALU_ADD, 1'b1, 6'b000001};
    vecs[9]  = '{OP_BEQ,  1'b1, 3, ALU_SUB, 1'b0, 6'b101000};
    vecs[10] = '{OP_BEQ,  1'b0, 3, ALU_SUB, 1'b0, 6'b001000};
    vecs[11] = '{OP_BNE,  1'b1, 3, ALU_SUB, 1'b0, 6'b001000};
    vecs[12] = '{OP_BNE,  1'b0, 3, ALU_SUB, 1'b0, 6'b101000};
    vecs[13] = '{OP_JUMP, 1'b0, 2, ALU_ADD, 1'b0, 6'b110000};
    vecs[14] = '{4'd13,   1'b0, 2, ALU_ADD, 1'b0, 6'b000000};

    // Outputs must be forced low while reset is held, even with a request ready.
    rst_n = 1'b0; stall = 1'b0; resume = 1'b0; zero = 1'b0;
    mem_ready = 1'b1; opcode = OP_ADD;
    #3;
    chk("reset_outputs_a", a_all, 36'h0);
    chk("reset_outputs_b", b_all, 24'h0);

    // Opcode table with mem_ready tied high.
    for (int v = 0; v < 15; v++) begin
      do_reset();
      opcode = vecs[v].op; zero = vecs[v].z; mem_ready = 1'b1;
      pulses = 0;
      last_obs = '0;
      for (int c = 0; c < vecs[v].lat; c++) begin
        #1;
        if (a_retired) pulses++;
        if (c == 2) begin
          chk("exec_alu_op", a_alu_op, vecs[v].alu);
          chk("exec_alu_src", a_alu_src, vecs[v].src);
        end
        if (c == vecs[v].lat - 1) begin
          last_obs = {a_pc_write, a_pc_src, a_reg_write, a_mem_to_reg, a_mem_write};
          chk("retire_cycle", a_retired, 1'b1);
          chk("retire_strobes", last_obs, vecs[v].last);
        end
        @(negedge clk);
      end
      #1;
      chk("retire_pulses", pulses, 1);
      chk("cnt_after", a_cnt, 16'd1);
      chk("back_to_fetch", a_state_o, 3'd0);
      $display("vec %0d op=%0d zero=%0b lat=%0d strobes=%b cnt=%0d",
               v, vecs[v].op, vecs[v].z, vecs[v].lat, last_obs, a_cnt);
    end

    // LW with memory ready delayed three cycles in MEM.
    do_reset();
    opcode = OP_LW;
    iord_cycles = 0;
    for (int c = 0; c < 8; c++) begin
      mem_ready = mr_seq[c];
      #1;
      chk("lw_state", a_state_o, lw_st[c]);
      if (a_iord && a_mem_read) iord_cycles++;
      if (c == 7) chk("lw_wb", {a_mem_to_reg, a_reg_write, a_retired}, 3'b111);
      @(negedge clk);
    end
    #1;
    chk("lw_mem_hold", iord_cycles, 4);
    chk("lw_cnt", a_cnt, 16'd1);
    $display("seq lw_delay iord_cycles=%0d cnt=%0d", iord_cycles, a_cnt);

    // Fetch timeout to FAULT; FAULT is sticky until reset.
    do_reset();
    mem_ready = 1'b0; opcode = OP_ADD;
    repeat (14) @(negedge clk);
    #1 chk("timeout_last_wait", a_state_o, 3'd0);
    @(negedge clk);
    #1 chk("timeout_fault", {a_state_o, a_fault}, {3'd6, 1'b1});
    mem_ready = 1'b1; resume = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("fault_sticky", {a_state_o, a_fault, a_mem_read}, {3'd6, 1'b1, 1'b0});
    rst_n = 1'b0;
    #1 chk("fault_reset", {a_state_o, a_fault}, 4'd0);
    $display("seq timeout state=%0d fault=%0b", a_state_o, a_fault);

    // mem_ready on the final allowed wait cycle still completes the fetch.
    do_reset();
    mem_ready = 1'b0; opcode = OP_ADD;
    repeat (14) @(negedge clk);
    mem_ready = 1'b1;
    #1 chk("boundary_fetch", {a_state_o, a_mem_read, a_ir_write}, {3'd0, 1'b1, 1'b1});
    @(negedge clk);
    #1 chk("boundary_decode", {a_state_o, a_fault}, {3'd1, 1'b0});
    $display("seq timeout_boundary state=%0d", a_state_o);

    // Asynchronous reset in the middle of MEM clears outputs immediately.
    do_reset();
    opcode = OP_LW; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("mid_mem", {a_state_o, a_iord, a_mem_read}, {3'd3, 1'b1, 1'b1});
    #1 rst_n = 1'b0;
    #1 chk("mid_mem_reset", a_all, 36'h0);
    $display("seq reset_mid_mem all=%0h", a_all);

    // Stall held two cycles during WB.
    do_reset();
    opcode = OP_ADDI; mem_ready = 1'b1;
    rw_cycles = 0;
    for (int c = 0; c < 7; c++) begin
      stall = (c < 6) ? st_seq[c] : 1'b0;
      #1;
      if (a_reg_write) rw_cycles++;
      if (c < 6) begin
        chk("stall_state", a_state_o, stw_st[c]);
        chk("stall_reg_write", a_reg_write, rw_exp[c]);
      end
      @(negedge clk);
    end
    #1;
    chk("stall_rw_once", rw_cycles, 1);
    chk("stall_cnt", a_cnt, 16'd1);
    $display("seq stall_wb reg_write_cycles=%0d cnt=%0d", rw_cycles, a_cnt);

    // HALT then resume five cycles later; stall has no effect in HALT.
    do_reset();
    opcode = OP_HALT; mem_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      stall = (c == 3 || c == 4 || c == 7);
      resume = (c == 7);
      #1;
      if (c >= 2) chk("halt_hold", {a_halt, a_pc_write, a_state_o}, {1'b1, 1'b0, 3'd5});
      @(negedge clk);
    end
    stall = 1'b0; resume = 1'b0; opcode = OP_ADD;
    #1;
    chk("halt_resume", {a_state_o, a_halt}, {3'd0, 1'b0});
    chk("halt_no_retire", a_cnt, 16'd0);
    $display("seq halt_resume state=%0d cnt=%0d", a_state_o, a_cnt);

    // Undefined opcode: NOP when lenient, FAULT when strict.
    do_reset();
    opcode = 4'd14; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("illegal_lenient", {a_state_o, a_fault, a_cnt}, {3'd0, 1'b0, 16'd1});
    chk("illegal_strict", {b_state_o, b_fault, b_mem_read, b_ir_write}, {3'd6, 1'b1, 1'b0, 1'b0});
    $display("seq illegal a_state=%0d b_state=%0d", a_state_o, b_state_o);

    // Counter wrap, seen on the 4-bit instance after 16 jumps.
    do_reset();
    opcode = OP_JUMP; mem_ready = 1'b1;
    repeat (30) @(negedge clk);
    #1 chk("wrap_before", b_cnt, 4'hF);
    repeat (2) @(negedge clk);
    #1;
    chk("wrap_after", b_cnt, 4'h0);
    chk("wrap_wide", a_cnt, 16'd16);
    $display("seq wrap b_cnt=%0d a_cnt=%0d", b_cnt, a_cnt);

    // Randomized stream: cycles = base latency + memory waits + stalled cycles.
    do_reset();
    model_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      int d0, d1;
      op = 4'($urandom_range(0, 15));
      if (op == OP_HALT) op = OP_JUMP;
      zero = 1'($urandom_range(0, 1));
      d0 = $urandom_range(0, 3);
      d1 = $urandom_range(0, 3);
      opcode = op;
      req = 0; waited = 0; stalls = 0; cyc = 0; taken = 1'b0; done = 1'b0;
      while (!done && cyc < 60) begin
        stall = ($urandom_range(0, 4) == 0);
        #1;
        if (stall) begin
          mem_ready = 1'($urandom_range(0, 1));
        end else if (a_mem_read || a_mem_write) begin
          if (waited < ((req == 0) ? d0 : d1)) begin
            mem_ready = 1'b0;
            waited++;
          end else begin
            mem_ready = 1'b1;
            req++;
            waited = 0;
          end
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
        #1;
        if (stall) stalls++;
        if (a_pc_write && a_pc_src != 2'd0) taken = 1'b1;
        if (a_retired) done = 1'b1;
        cyc++;
        @(negedge clk);
      end
      stall = 1'b0;
      model_cnt++;
      exp_cyc = lat_of(op) + d0 + stalls + ((op == OP_LW || op == OP_SW) ? d1 : 0);
      #1;
      chk("rand_cycles", cyc, exp_cyc);
      chk("rand_taken", taken, taken_of(op, zero));
      chk("rand_cnt", a_cnt, 16'(model_cnt));
      $display("rand %0d op=%0d zero=%0b d0=%0d d1=%0d stalls=%0d cycles=%0d exp=%0d cnt=%0d",
               n, op, zero, d0, d1, stalls, cyc, exp_cyc, a_cnt);
    end
    chk("rand_no_fault", a_fault, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
